// File: rtl/composite_dc_restore.sv
// Back-porch clamp: measures per-line sync-tip and back-porch levels, IIR-smooths them,
// and emits blank-referenced video plus a signal-present flag.
module composite_dc_restore #(
   parameter int                DATA_W         = 12,
   parameter int                TIP_START      = 32,
   parameter int                TIP_LEN_LOG2   = 6,
   parameter int                PORCH_START    = 240,
   parameter int                PORCH_LEN_LOG2 = 6,
   parameter int                IIR_SHIFT      = 2,
   parameter logic [DATA_W-1:0] MIN_SYNC_AMP   = 12'd200,
   parameter int                LOCK_LINES     = 8,
   parameter int                LINE_TIMEOUT   = 4095
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              h_sync_pulse,
   output logic [DATA_W-1:0] video_out,
   output logic              video_valid,
   output logic [DATA_W-1:0] blank_level,
   output logic [DATA_W-1:0] tip_level,
   output logic [DATA_W-1:0] sync_amp,
   output logic              signal_ok
);

   localparam int CNT_W  = 12;
   localparam int TACC_W = DATA_W + TIP_LEN_LOG2;
   localparam int PACC_W = DATA_W + PORCH_LEN_LOG2;
   localparam int GC_W   = $clog2(LOCK_LINES + 1);
   localparam logic [CNT_W-1:0] TIP_FIRST   = CNT_W'(TIP_START);
   localparam logic [CNT_W-1:0] TIP_LAST    = CNT_W'(TIP_START + (1 << TIP_LEN_LOG2) - 1);
   localparam logic [CNT_W-1:0] PORCH_FIRST = CNT_W'(PORCH_START);
   localparam logic [CNT_W-1:0] PORCH_LAST  = CNT_W'(PORCH_START + (1 << PORCH_LEN_LOG2) - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(LINE_TIMEOUT);
   localparam logic [GC_W-1:0]  LOCK_CNT    = GC_W'(LOCK_LINES);

   typedef enum logic [2:0] {IDLE, WAIT_TIP, TIP, WAIT_PORCH, PORCH, ACTIVE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [TACC_W-1:0] acc_tip;
   logic [PACC_W-1:0] acc_porch;
   logic              upd_p1;
   logic              levels_loaded;
   logic [GC_W-1:0]   good_cnt;
   logic              tmo;
   logic [DATA_W-1:0] tip_avg, porch_avg, tip_nx, blank_nx, amp_nx;
   logic [GC_W-1:0]   good_nx;

   // Clamp a widened signed result into the unsigned code range.
   function automatic logic [DATA_W-1:0] sat_u(input logic signed [DATA_W+1:0] v);
      if (v[DATA_W+1]) return '0;
      if (v[DATA_W])   return '1;
      return v[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] sub_sat0(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic signed [DATA_W+1:0] d;
      d = $signed({2'b00, a}) - $signed({2'b00, b});
      return sat_u(d);
   endfunction

   function automatic logic [DATA_W-1:0] iir_step(input logic [DATA_W-1:0] level,
                                                  input logic [DATA_W-1:0] avg);
      logic signed [DATA_W+1:0] lvl, step;
      lvl  = $signed({2'b00, level});
      step = ($signed({2'b00, avg}) - lvl) >>> IIR_SHIFT;
      return sat_u(lvl + step);
   endfunction

   assign tmo       = !h_sync_pulse && (state != IDLE) && (cnt == TIMEOUT_CNT);
   assign tip_avg   = DATA_W'(acc_tip >> TIP_LEN_LOG2);
   assign porch_avg = DATA_W'(acc_porch >> PORCH_LEN_LOG2);
   assign tip_nx    = levels_loaded ? iir_step(tip_level, tip_avg) : tip_avg;
   assign blank_nx  = levels_loaded ? iir_step(blank_level, porch_avg) : porch_avg;
   assign amp_nx    = sub_sat0(blank_nx, tip_nx);
   assign good_nx   = (good_cnt == LOCK_CNT) ? good_cnt : good_cnt + 1'b1;

   // Stage p0: line timing and window accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         acc_tip   <= '0;
         acc_porch <= '0;
         upd_p1    <= 1'b0;
      end else begin
         upd_p1 <= 1'b0;
         if (h_sync_pulse) begin
            cnt       <= sample_valid ? CNT_W'(1) : '0;
            state     <= WAIT_TIP;
            acc_tip   <= '0;
            acc_porch <= '0;
         end else begin
            if (sample_valid && cnt != '1) cnt <= cnt + 1'b1;
            if (tmo) begin
               state <= IDLE;
            end else if (sample_valid) begin
               case (state)
                  WAIT_TIP: if (cnt == TIP_FIRST) begin
                     acc_tip <= TACC_W'(adc_data);
                     state   <= TIP;
                  end
                  TIP: if (cnt == PORCH_FIRST) begin
                     acc_porch <= PACC_W'(adc_data);
                     state     <= PORCH;
                  end else begin
                     acc_tip <= acc_tip + TACC_W'(adc_data);
                     if (cnt == TIP_LAST) state <= WAIT_PORCH;
                  end
                  WAIT_PORCH: if (cnt == PORCH_FIRST) begin
                     acc_porch <= PACC_W'(adc_data);
                     state     <= PORCH;
                  end
                  PORCH: begin
                     acc_porch <= acc_porch + PACC_W'(adc_data);
                     if (cnt == PORCH_LAST) begin
                        state  <= ACTIVE;
                        upd_p1 <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Stage p1: level filter, sync amplitude and lock qualification
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_level   <= '0;
         tip_level     <= '0;
         sync_amp      <= '0;
         levels_loaded <= 1'b0;
         good_cnt      <= '0;
         signal_ok     <= 1'b0;
      end else if (tmo) begin
         good_cnt  <= '0;
         signal_ok <= 1'b0;
      end else if (upd_p1) begin
         blank_level   <= blank_nx;
         tip_level     <= tip_nx;
         sync_amp      <= amp_nx;
         levels_loaded <= 1'b1;
         if (amp_nx >= MIN_SYNC_AMP) begin
            good_cnt <= good_nx;
            if (good_nx == LOCK_CNT) signal_ok <= 1'b1;
         end else begin
            good_cnt  <= '0;
            signal_ok <= 1'b0;
         end
      end
   end

   // Video path: one clock latency, never gated by lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         video_out   <= '0;
         video_valid <= 1'b0;
      end else begin
         video_valid <= sample_valid;
         if (sample_valid) video_out <= sub_sat0(adc_data, blank_level);
      end
   end

endmodule
